// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI request sequencer: FSM states, request codes and the
// queued command record.
package spi_seq_pkg;

    localparam int unsigned SEQ_TRF_BIT = 8;

    localparam logic [1:0] REQ_NOP  = 2'b00;
    localparam logic [1:0] REQ_TX   = 2'b01;
    localparam logic [1:0] REQ_RX   = 2'b10;
    localparam logic [1:0] REQ_TXRX = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT,
        ST_GAP
    } seq_state_t;

    typedef struct packed {
        logic [1:0]             req;
        logic [SEQ_TRF_BIT-1:0] din_master;
        logic [SEQ_TRF_BIT-1:0] din_slave;
        logic [7:0]             wait_dur;
    } seq_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Show-ahead synchronous FIFO of seq_cmd_t; the head entry is visible on data_o
// while not empty.
module spi_cmd_fifo
    import spi_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  seq_cmd_t                 data_i,
    input  logic                     pop_i,
    output seq_cmd_t                 data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    seq_cmd_t       mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    level_q;
    logic           do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_req_sequencer.sv
// Queues host SPI transfer commands and issues them one at a time to spi_top,
// returning the captured data on a one-cycle result strobe.
module spi_req_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned SPI_TRF_BIT    = 8,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned ISSUE_CYCLES   = 2,
    parameter int unsigned GAP_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [1:0]                    s_req,
    input  logic [SPI_TRF_BIT-1:0]        s_din_master,
    input  logic [SPI_TRF_BIT-1:0]        s_din_slave,
    input  logic [7:0]                    s_wait,
    output logic [1:0]                    req,
    output logic [SPI_TRF_BIT-1:0]        din_master,
    output logic [SPI_TRF_BIT-1:0]        din_slave,
    output logic [7:0]                    wait_duration,
    input  logic                          done_tx,
    input  logic                          done_rx,
    input  logic [SPI_TRF_BIT-1:0]        dout_master,
    input  logic [SPI_TRF_BIT-1:0]        dout_slave,
    output logic                          r_valid,
    output logic [1:0]                    r_req,
    output logic [SPI_TRF_BIT-1:0]        r_dout_master,
    output logic [SPI_TRF_BIT-1:0]        r_dout_slave,
    output logic                          r_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    if (SPI_TRF_BIT != SEQ_TRF_BIT) begin : g_bad_width
        $error("spi_req_sequencer: SPI_TRF_BIT must match spi_seq_pkg::SEQ_TRF_BIT");
    end

    localparam int unsigned CNT_A   = (ISSUE_CYCLES > GAP_CYCLES) ? ISSUE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (CNT_A > TIMEOUT_CYCLES) ? CNT_A : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    seq_state_t               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [1:0]               code_q, code_d;
    logic [SPI_TRF_BIT-1:0]   dinm_q, dinm_d, dins_q, dins_d;
    logic [7:0]               wait_q, wait_d;
    logic                     timeout_q, timeout_d;
    logic                     done_tx_q, done_rx_q, tx_flag_q, rx_flag_q;
    logic [SPI_TRF_BIT-1:0]   r_dm_q, r_ds_q;
    logic                     pop, clr, capture, tx_rise, rx_rise, need_tx, need_rx, done_ok;
    logic                     fifo_full, fifo_empty;
    seq_cmd_t                 push_cmd, head;

    assign push_cmd = '{req: s_req, din_master: s_din_master, din_slave: s_din_slave, wait_dur: s_wait};

    spi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (s_valid && !fifo_full),
        .data_i  (push_cmd),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign s_ready = !fifo_full;
    assign tx_rise = done_tx && !done_tx_q;
    assign rx_rise = done_rx && !done_rx_q;
    assign need_tx = (code_q == REQ_TX) || (code_q == REQ_TXRX);
    assign need_rx = (code_q == REQ_RX) || (code_q == REQ_TXRX);
    assign done_ok = (!need_tx || tx_flag_q) && (!need_rx || rx_flag_q);
    assign capture = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        dinm_d    = dinm_q;
        dins_d    = dins_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        pop       = 1'b0;
        clr       = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                pop       = 1'b1;
                clr       = 1'b1;
                code_d    = head.req;
                dinm_d    = head.din_master;
                dins_d    = head.din_slave;
                wait_d    = head.wait_dur;
                timeout_d = 1'b0;
                cnt_d     = '0;
                state_d   = (head.req == REQ_NOP) ? ST_RESULT : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cnt_q == CW'(ISSUE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (done_ok) begin
                    state_d = ST_RESULT;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESULT: begin
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                              cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            dinm_q    <= '0;
            dins_q    <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            dinm_q    <= dinm_d;
            dins_q    <= dins_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Completion edges are only captured while a command is outstanding, so
    // results stay stable through GAP until the next LOAD clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_tx_q <= 1'b0;
            done_rx_q <= 1'b0;
            tx_flag_q <= 1'b0;
            rx_flag_q <= 1'b0;
            r_dm_q    <= '0;
            r_ds_q    <= '0;
        end else begin
            done_tx_q <= done_tx;
            done_rx_q <= done_rx;
            if (clr) begin
                tx_flag_q <= 1'b0;
                rx_flag_q <= 1'b0;
                r_dm_q    <= '0;
                r_ds_q    <= '0;
            end else if (capture) begin
                if (tx_rise) begin
                    tx_flag_q <= 1'b1;
                    r_ds_q    <= dout_slave;
                end
                if (rx_rise) begin
                    rx_flag_q <= 1'b1;
                    r_dm_q    <= dout_master;
                end
            end
        end
    end

    assign req           = (state_q == ST_ISSUE) ? code_q : REQ_NOP;
    assign din_master    = dinm_q;
    assign din_slave     = dins_q;
    assign wait_duration = wait_q;
    assign r_valid       = (state_q == ST_RESULT);
    assign r_req         = code_q;
    assign r_dout_master = r_dm_q;
    assign r_dout_slave  = r_ds_q;
    assign r_timeout     = timeout_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_req_sequencer.sv
// Directed bench for spi_req_sequencer; the bench itself plays the role of spi_top.
module tb_spi_req_sequencer;
    import spi_seq_pkg::*;

    localparam int unsigned GAP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] s_req = '0;
    logic [7:0] s_din_master = '0, s_din_slave = '0, s_wait = '0;
    logic [1:0] req;
    logic [7:0] din_master, din_slave, wait_duration;
    logic       done_tx = 1'b0, done_rx = 1'b0;
    logic [7:0] dout_master = '0, dout_slave = '0;
    logic       r_valid;
    logic [1:0] r_req;
    logic [7:0] r_dout_master, r_dout_slave;
    logic       r_timeout, busy;
    logic [3:0] level;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_strobe = 0;

    spi_req_sequencer #(
        .SPI_TRF_BIT(8), .FIFO_DEPTH(8), .ISSUE_CYCLES(2),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_req(s_req),
        .s_din_master(s_din_master), .s_din_slave(s_din_slave), .s_wait(s_wait),
        .req(req), .din_master(din_master), .din_slave(din_slave),
        .wait_duration(wait_duration), .done_tx(done_tx), .done_rx(done_rx),
        .dout_master(dout_master), .dout_slave(dout_slave), .r_valid(r_valid),
        .r_req(r_req), .r_dout_master(r_dout_master), .r_dout_slave(r_dout_slave),
        .r_timeout(r_timeout), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] dm, input logic [7:0] ds, input logic [7:0] w);
        s_valid = 1'b1; s_req = c; s_din_master = dm; s_din_slave = ds; s_wait = w;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("idle", 32'(busy), 0);
    endtask

    // Acts as spi_top for one command: completion raised on the first ISSUE cycle.
    task automatic respond(input logic [1:0] c, input logic [7:0] dm, input logic [7:0] ds);
        if (c == REQ_NOP) begin
            tick();
            for (int k = 0; k < 40 && !r_valid; k++) tick();
        end else begin
            for (int k = 0; k < 64 && req == 2'b00; k++) tick();
            chk("issue_req", 32'(req), 32'(c));
            done_tx = c[0]; done_rx = c[1]; dout_slave = dm; dout_master = ds;
            tick();
            done_tx = 1'b0; done_rx = 1'b0;
            tick();
            chk("early_no_strobe", 32'(r_valid), 0);
            tick();
        end
        chk("resp_valid", 32'(r_valid), 1);
        chk("resp_req", 32'(r_req), 32'(c));
        chk("resp_dout_slave", 32'(r_dout_slave), c[0] ? 32'(dm) : 0);
        chk("resp_dout_master", 32'(r_dout_master), c[1] ? 32'(ds) : 0);
        chk("resp_timeout", 32'(r_timeout), 0);
    endtask

    logic [1:0] q_code [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
    logic       seen;

    initial begin
        // 1: reset
        repeat (3) tick();
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_rvalid", 32'(r_valid), 0);
        chk("rst_rdata", 32'({r_dout_master, r_dout_slave, r_req, r_timeout}), 0);
        chk("rst_din", 32'({din_master, din_slave, wait_duration}), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // 2: single M->S command, exact latencies
        push(REQ_TX, 8'hB8, 8'h00, 8'h05);
        chk("t2_level", 32'(level), 1);
        chk("t2_idle_yet", 32'(busy), 0);
        tick();
        chk("t2_load_busy", 32'(busy), 1);
        chk("t2_load_req", 32'(req), 0);
        tick();
        chk("t2_req0", 32'(req), 1);
        chk("t2_din_master", 32'(din_master), 32'hB8);
        chk("t2_wait", 32'(wait_duration), 5);
        chk("t2_popped", 32'(level), 0);
        tick();
        chk("t2_req1", 32'(req), 1);
        tick();
        chk("t2_req_off", 32'(req), 0);
        done_tx = 1'b1; dout_slave = 8'hB8;
        tick();
        chk("t2_no_strobe", 32'(r_valid), 0);
        tick();
        chk("t2_valid", 32'(r_valid), 1);
        chk("t2_rreq", 32'(r_req), 1);
        chk("t2_dout_slave", 32'(r_dout_slave), 32'hB8);
        chk("t2_timeout", 32'(r_timeout), 0);
        done_tx = 1'b0;
        tick();
        chk("t2_one_strobe", 32'(r_valid), 0);
        repeat (9) tick();
        chk("t2_gap_busy", 32'(busy), 1);
        chk("t2_din_held", 32'(din_master), 32'hB8);
        tick();
        chk("t2_gap_done", 32'(busy), 0);

        // 3: both directions, strobe only after both dones
        push(REQ_TXRX, 8'h3C, 8'hA2, 8'h07);
        repeat (2) tick();
        chk("t3_req", 32'(req), 3);
        chk("t3_din_slave", 32'(din_slave), 32'hA2);
        repeat (2) tick();
        done_tx = 1'b1; dout_slave = 8'h3C;
        repeat (2) tick();
        chk("t3_rx_pending", 32'(r_valid), 0);
        done_tx = 1'b0; done_rx = 1'b1; dout_master = 8'hA2;
        tick();
        chk("t3_no_strobe", 32'(r_valid), 0);
        tick();
        chk("t3_valid", 32'(r_valid), 1);
        chk("t3_dout_slave", 32'(r_dout_slave), 32'h3C);
        chk("t3_dout_master", 32'(r_dout_master), 32'hA2);
        chk("t3_rreq", 32'(r_req), 3);
        done_rx = 1'b0;
        wait_idle();

        // 4: fill the FIFO behind a stalled command, then drain in order
        push(REQ_TX, 8'h11, 8'h00, 8'h00);
        repeat (4) tick();
        chk("t4_stalled", 32'({busy, req}), 32'h4);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_req = q_code[i];
            s_din_master = 8'(8'h20 + i); s_din_slave = 8'(8'h40 + i); s_wait = 8'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("t4_full_level", 32'(level), 8);
        chk("t4_not_ready", 32'(s_ready), 0);
        s_valid = 1'b1; s_req = REQ_TXRX; s_din_master = 8'hFF; s_din_slave = 8'hFF;
        tick();
        s_valid = 1'b0;
        chk("t4_reject", 32'(level), 8);
        done_tx = 1'b1; dout_slave = 8'h11;
        tick();
        done_tx = 1'b0;
        tick();
        chk("t4_head_valid", 32'(r_valid), 1);
        chk("t4_head_dout", 32'(r_dout_slave), 32'h11);
        last_strobe = cyc;
        for (int i = 0; i < 8; i++) begin
            respond(q_code[i], 8'(8'h20 + i), 8'(8'h40 + i));
            chk("t4_spacing", 32'((cyc - last_strobe) > GAP), 1);
            last_strobe = cyc;
        end
        chk("t4_drained", 32'(level), 0);
        wait_idle();

        // 5: timeout with a stale done_tx edge captured along the way
        push(REQ_RX, 8'h00, 8'h55, 8'h00);
        repeat (9) tick();
        done_tx = 1'b1; dout_slave = 8'h77;
        tick();
        done_tx = 1'b0;
        repeat (57) tick();
        chk("t5_before_timeout", 32'(r_valid), 0);
        tick();
        chk("t5_valid", 32'(r_valid), 1);
        chk("t5_timeout", 32'(r_timeout), 1);
        chk("t5_rreq", 32'(r_req), 2);
        chk("t5_stale_latched", 32'(r_dout_slave), 32'h77);
        chk("t5_no_rx_data", 32'(r_dout_master), 0);
        wait_idle();
        push(REQ_TX, 8'h9A, 8'h00, 8'h03);
        respond(REQ_TX, 8'h9A, 8'h00);
        wait_idle();

        // 6: asynchronous reset during WAIT with commands queued
        push(REQ_TX, 8'hC3, 8'h00, 8'h00);
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_req = REQ_TX; s_din_master = 8'(8'h60 + i);
            tick();
        end
        s_valid = 1'b0;
        chk("t6_queued", 32'(level), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_level", 32'(level), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_ready", 32'(s_ready), 1);
        chk("t6_async_out", 32'({req, din_master, r_valid}), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (r_valid || busy) seen = 1'b1;
        end
        chk("t6_no_result", 32'(seen), 0);
        chk("t6_level_after", 32'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_req_sequencer.md
# spi_req_sequencer

Upstream command stage for `spi_top`. It buffers host transfer commands in a FIFO and issues them one at a time on `spi_top`'s `req`/`din_master`/`din_slave`/`wait_duration` inputs. It waits for the matching `done_tx`/`done_rx` completions, then returns the captured `dout_master`/`dout_slave` on a result strobe. It replaces hand-sequenced stimulus with a self-pacing command queue.

## Interface
Parameters:
- `SPI_TRF_BIT`, 8 — transfer width; must equal `spi_top`'s.
- `FIFO_DEPTH`, 8 — command entries; power of 2, at least 2.
- `ISSUE_CYCLES`, 2 — cycles `req` is held non-zero per command.
- `GAP_CYCLES`, 10 — idle cycles between commands.
- `TIMEOUT_CYCLES`, 4096 — maximum wait for completion.

Ports:
- `clk` in 1 — single clock, 100 MHz nominal.
- `rst_n` in 1 — reset; asynchronous, active-low. This block does not drive `spi_top`'s `rst`.
- `s_valid` in 1 — command valid.
- `s_ready` out 1 — command accept; equals `!full`.
- `s_req` in 2 — command code: 01 = M->S, 10 = S->M, 11 = both, 00 = no-op.
- `s_din_master` in SPI_TRF_BIT — master TX byte.
- `s_din_slave` in SPI_TRF_BIT — slave TX byte.
- `s_wait` in 8 — passed through to `wait_duration`.
- `req` out 2 — to `spi_top`.
- `din_master` out SPI_TRF_BIT — to `spi_top`.
- `din_slave` out SPI_TRF_BIT — to `spi_top`.
- `wait_duration` out 8 — to `spi_top`.
- `done_tx` in 1 — from `spi_top`.
- `done_rx` in 1 — from `spi_top`.
- `dout_master` in SPI_TRF_BIT — from `spi_top`.
- `dout_slave` in SPI_TRF_BIT — from `spi_top`.
- `r_valid` out 1 — one-cycle result strobe.
- `r_req` out 2 — code of the completed command.
- `r_dout_master` out SPI_TRF_BIT — captured `dout_master`.
- `r_dout_slave` out SPI_TRF_BIT — captured `dout_slave`.
- `r_timeout` out 1 — result ended by timeout.
- `busy` out 1 — state is not IDLE.
- `level` out $clog2(FIFO_DEPTH)+1 — FIFO occupancy.

## Operation
- **FIFO**
  - Push when `s_valid && s_ready`.
  - Pop only in LOAD.
  - Push and pop in the same cycle are both honoured; `level` is then unchanged.
  - Push while full is impossible because `s_ready` is 0.
- **Completion detection.** `done_tx` and `done_rx` are rising-edge detected against registered copies. Each rise sets a sticky flag.
  - Rise of `done_tx` latches `dout_slave` into `r_dout_slave`.
  - Rise of `done_rx` latches `dout_master` into `r_dout_master`.
- **FSM** (state type `seq_state_t`):
  - IDLE: if `level != 0` go to LOAD.
  - LOAD: pop; register `din_master`, `din_slave`, `wait_duration`, and the current code. Clear both flags and the result registers. Code 00 goes to RESULT; any other code goes to ISSUE.
  - ISSUE: `req` = code for `ISSUE_CYCLES` cycles, then WAIT.
  - WAIT: `req` = 00. Exit when every required flag is set: `done_tx` for bit0, `done_rx` for bit1. Go to RESULT when satisfied, or with `r_timeout` = 1 when the wait counter reaches `TIMEOUT_CYCLES`. A completion edge is accepted from ISSUE onward.
  - RESULT: `r_valid` = 1 for one cycle, then GAP.
  - GAP: wait `GAP_CYCLES` cycles, then IDLE.
- **Held outputs.** `din_*` and `wait_duration` hold their last loaded values until the next LOAD.
- **No-op results.** A 00 command returns both `r_dout_*` = 0 and `r_timeout` = 0.

## Timing
- **Reset values.**
  - `req`, `din_*`, `wait_duration`, `r_*`, `busy` = 0.
  - `s_ready` = 1; `level` = 0; FIFO empty; state IDLE.
- **Reset mid-operation.** All state is discarded immediately, including queued commands; no result is produced. Deasserting `rst_n` takes effect at the next clock edge.
- **Issue latency.** A push accepted at edge N into an empty, IDLE sequencer gives LOAD after edge N+1 and `req` non-zero after edge N+2.
- **Completion latency.** A done rise seen at edge M (the last one required) gives `r_valid` after edge M+1.
- **Early completion.** A completion rise during ISSUE is retained. WAIT then exits on its first cycle.
- **Stale edges.** A rise of an unrequired `done_*` is ignored for exit but still latched.
- **Timeout count.** The wait counter counts WAIT cycles only. A timeout pulses `r_valid` with whatever partial data was captured.

## Structure
- **Package `spi_seq_pkg`:**
  - `seq_state_t` enum.
  - Request-code localparams `REQ_NOP`, `REQ_TX`, `REQ_RX`, `REQ_TXRX`.
  - Packed struct `seq_cmd_t` = {req, din_master, din_slave, wait}.
- **Sub-module `spi_cmd_fifo`:** a parameterised synchronous FIFO of `seq_cmd_t` exposing `full`, `empty`, and `level`. The sequencer instantiates it once.

## Test plan
1. Reset with `rst_n` = 0, then release → all outputs at reset values, `s_ready` = 1, `level` = 0.
2. Push {01, din_master = 0xB8} to a live `spi_top` → `req` = 01 for 2 cycles; one `r_valid` with `r_req` = 01, `r_dout_slave` = 0xB8, `r_timeout` = 0.
3. Push {11, din_master = 0x3C, din_slave = 0xA2} → `r_valid` only after both dones, with `r_dout_slave` = 0x3C and `r_dout_master` = 0xA2.
4. Push `FIFO_DEPTH` + 1 commands back-to-back with the sequencer stalled → `s_ready` = 0 once `level` = 8. Results then emerge in push order, separated by at least `GAP_CYCLES`.
5. Push {10} with `done_rx` tied low and `TIMEOUT_CYCLES` = 64 → `r_valid` after 64 WAIT cycles with `r_timeout` = 1; the next command proceeds normally.
6. Pull `rst_n` low during WAIT with 3 commands queued → outputs reset asynchronously, `level` = 0, and no `r_valid` after release.
